// File: rtl/memory_responder_pkg.sv
// Shared definitions for the memory responder: FSM state encoding, default widths
// and the wait-counter load helper.
package memory_responder_pkg;

    localparam int DIGIT_DEF        = 32;
    localparam int ADDRWIDTH_DEF    = 16;
    localparam int DEPTHLOG2_DEF    = 8;
    localparam int WAITCYCLES_DEF   = 2;
    localparam int PROTECTWORDS_DEF = 64;

    // Wait states are limited to 0..15, so four bits always hold the counter.
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        RESPOND = 2'd2
    } state_e;

    function automatic logic [CNT_W-1:0] wait_load(input int waitcycles);
        return (waitcycles > 0) ? CNT_W'(waitcycles - 1) : '0;
    endfunction

endpackage

// File: rtl/memory_responder_if.sv
// Initiator/responder access bus of the memory responder.
interface memory_responder_if #(
    parameter int DIGIT     = 32,
    parameter int ADDRWIDTH = 16
);
    logic                 MemRequest;
    logic                 MemWrite;
    logic [ADDRWIDTH-1:0] MemAddress;
    logic [DIGIT-1:0]     WriteData;
    logic [DIGIT-1:0]     MemData;
    logic                 Ready;
    logic                 WriteFault;

    modport master (
        output MemRequest, MemWrite, MemAddress, WriteData,
        input  MemData, Ready, WriteFault
    );

    modport slave (
        input  MemRequest, MemWrite, MemAddress, WriteData,
        output MemData, Ready, WriteFault
    );
endinterface

// File: rtl/memory_responder_array.sv
// MemoryArray: word storage with one synchronous write port and two asynchronous
// read ports (access and debug probe). Contents are never reset.
module MemoryArray #(
    parameter int DIGIT     = 32,
    parameter int DEPTHLOG2 = 8
) (
    input  logic                 CLK,
    input  logic                 we_i,
    input  logic [DEPTHLOG2-1:0] addr_i,
    input  logic [DIGIT-1:0]     wdata_i,
    output logic [DIGIT-1:0]     rdata_o,
    input  logic [DEPTHLOG2-1:0] probe_addr_i,
    output logic [DIGIT-1:0]     probe_data_o
);

    logic [DIGIT-1:0] mem_q [2**DEPTHLOG2];

    always_ff @(posedge CLK) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    assign rdata_o      = mem_q[addr_i];
    assign probe_data_o = mem_q[probe_addr_i];

endmodule

// File: rtl/memory_responder.sv
// Memory responder: wait-stated single-port memory slave with a debug probe port.
// Optional MEM_WRITE_PROTECT_EN drops writes below PROTECTWORDS and flags WriteFault.
//
// state   | meaning
// IDLE    | no access in flight; a sampled MemRequest starts one
// WAIT    | burning wait states; counter counts down to 0
// RESPOND | Ready strobe cycle; write commits at the edge leaving this state
module memory_responder
    import memory_responder_pkg::*;
#(
    parameter int DIGIT        = DIGIT_DEF,
    parameter int ADDRWIDTH    = ADDRWIDTH_DEF,
    parameter int DEPTHLOG2    = DEPTHLOG2_DEF,
    parameter int WAITCYCLES   = WAITCYCLES_DEF,
    parameter int PROTECTWORDS = PROTECTWORDS_DEF
) (
    input  logic                 CLK,
    input  logic                 reset,
    memory_responder_if.slave    bus,
    input  logic [DEPTHLOG2-1:0] ProbeAddress,
    output logic [DIGIT-1:0]     ProbeData
);

    localparam logic [CNT_W-1:0] CNT_LOAD = wait_load(WAITCYCLES);

    state_e               state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic                 ready_q;
    logic [DIGIT-1:0]     mem_data_q;
    logic                 fault_q;

    logic [DEPTHLOG2-1:0] word_idx;
    logic [DIGIT-1:0]     rd_data;
    logic                 wr_blocked;
    logic                 wr_en;

    // Byte address to word index; upper bits wrap.
    assign word_idx = bus.MemAddress[DEPTHLOG2+1:2];

`ifdef MEM_WRITE_PROTECT_EN
    assign wr_blocked = (int'(word_idx) < PROTECTWORDS);
`else
    assign wr_blocked = 1'b0;
`endif

    // Reset in the RESPOND cycle must still suppress the write.
    assign wr_en = reset && (state_q == RESPOND) && bus.MemWrite && !wr_blocked;

    always_ff @(posedge CLK) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            ready_q    <= 1'b0;
            mem_data_q <= '0;
            fault_q    <= 1'b0;
        end else begin
            ready_q    <= 1'b0;
            mem_data_q <= '0;
            case (state_q)
                IDLE: begin
                    if (bus.MemRequest) begin
                        if (WAITCYCLES == 0) begin
                            state_q    <= RESPOND;
                            ready_q    <= 1'b1;
                            mem_data_q <= bus.MemWrite ? '0 : rd_data;
                        end else begin
                            state_q <= WAIT;
                            cnt_q   <= CNT_LOAD;
                        end
                    end
                end
                WAIT: begin
                    if (!bus.MemRequest) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else if (cnt_q == '0) begin
                        state_q    <= RESPOND;
                        ready_q    <= 1'b1;
                        mem_data_q <= bus.MemWrite ? '0 : rd_data;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                RESPOND: begin
                    state_q <= IDLE;
                    if (bus.MemWrite && wr_blocked) begin
                        fault_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign bus.Ready      = ready_q;
    assign bus.MemData    = mem_data_q;
    assign bus.WriteFault = fault_q;

    MemoryArray #(
        .DIGIT     (DIGIT),
        .DEPTHLOG2 (DEPTHLOG2)
    ) u_array (
        .CLK          (CLK),
        .we_i         (wr_en),
        .addr_i       (word_idx),
        .wdata_i      (bus.WriteData),
        .rdata_o      (rd_data),
        .probe_addr_i (ProbeAddress),
        .probe_data_o (ProbeData)
    );

endmodule

// File: tb/tb_memory_responder.sv
// Scoreboard bench for memory_responder: one instance with two wait states, one with none.
module tb_memory_responder;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic       rst_n;
    logic [7:0] pa2, pa0;
    logic [31:0] pd2, pd0;

    memory_responder_if #(.DIGIT(32), .ADDRWIDTH(16)) b2 ();
    memory_responder_if #(.DIGIT(32), .ADDRWIDTH(16)) b0 ();

    memory_responder #(.WAITCYCLES(2)) u_dut2 (
        .CLK(CLK), .reset(rst_n), .bus(b2.slave), .ProbeAddress(pa2), .ProbeData(pd2)
    );
    memory_responder #(.WAITCYCLES(0)) u_dut0 (
        .CLK(CLK), .reset(rst_n), .bus(b0.slave), .ProbeAddress(pa0), .ProbeData(pd0)
    );

    typedef struct {
        bit          chk;
        logic [31:0] data;
    } exp_t;

    exp_t sb2[$];
    exp_t sb0[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   mon_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every Ready pops one expected response; MemData must be 0 otherwise.
    always @(negedge CLK) begin : monitor
        exp_t e;
        if (mon_en) begin
            if (b2.Ready) begin
                if (sb2.size() == 0) check("unexpected_ready_w2", 32'(b2.Ready), 32'd0);
                else begin
                    e = sb2.pop_front();
                    if (e.chk) check("rd_data_w2", b2.MemData, e.data);
                end
            end else check("idle_memdata_w2", b2.MemData, 32'd0);
            if (b0.Ready) begin
                if (sb0.size() == 0) check("unexpected_ready_w0", 32'(b0.Ready), 32'd0);
                else begin
                    e = sb0.pop_front();
                    if (e.chk) check("rd_data_w0", b0.MemData, e.data);
                end
            end else check("idle_memdata_w0", b0.MemData, 32'd0);
        end
    end

    task automatic drive(input bit sel, input bit req, input bit w, input logic [15:0] a,
                         input logic [31:0] d);
        if (sel) begin
            b0.MemRequest = req; b0.MemWrite = w; b0.MemAddress = a; b0.WriteData = d;
        end else begin
            b2.MemRequest = req; b2.MemWrite = w; b2.MemAddress = a; b2.WriteData = d;
        end
    endtask

    // Counts edges until Ready; a timeout shows up as a latency mismatch.
    task automatic wait_ready(input bit sel, input int exp_lat, input string name);
        int n;
        bit got;
        n = 0;
        got = 1'b0;
        while (!got && n < 20) begin
            @(posedge CLK); #1;
            n++;
            got = sel ? b0.Ready : b2.Ready;
        end
        check(name, 32'(n), 32'(exp_lat));
    endtask

    task automatic push(input bit sel, input bit chk, input logic [31:0] d);
        exp_t e;
        e.chk  = chk;
        e.data = d;
        if (sel) sb0.push_back(e);
        else     sb2.push_back(e);
    endtask

    task automatic access(input bit sel, input bit w, input logic [15:0] a, input logic [31:0] d,
                          input int lat, input logic [31:0] exp_rd, input string name);
        push(sel, !w, exp_rd);
        drive(sel, 1'b1, w, a, d);
        wait_ready(sel, lat, name);
        drive(sel, 1'b0, w, a, d);
        @(posedge CLK); #1;
    endtask

    task automatic probe(input bit sel, input logic [7:0] idx, input logic [31:0] exp,
                         input string name);
        if (sel) pa0 = idx; else pa2 = idx;
        #1;
        check(name, sel ? pd0 : pd2, exp);
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        @(posedge CLK); #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        pa2 = '0;
        pa0 = '0;
        drive(1'b0, 1'b0, 1'b0, 16'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 16'h0, 32'h0);
        repeat (3) @(posedge CLK);
        #1;
        rst_n  = 1'b1;
        check("rst_ready_w2", 32'(b2.Ready), 32'd0);
        check("rst_memdata_w2", b2.MemData, 32'd0);
        check("rst_fault_w2", 32'(b2.WriteFault), 32'd0);
        check("rst_ready_w0", 32'(b0.Ready), 32'd0);
        mon_en = 1'b1;

        // Write then read back, including wrapped / unaligned aliases of word 0x40.
        access(1'b0, 1'b1, 16'h0100, 32'hDEADBEEF, 3, 32'h0, "wr_0100_lat");
        probe(1'b0, 8'h40, 32'hDEADBEEF, "probe_40");
        access(1'b0, 1'b0, 16'h0100, 32'h0, 3, 32'hDEADBEEF, "rd_0100_lat");
        access(1'b0, 1'b0, 16'h8102, 32'h0, 3, 32'hDEADBEEF, "rd_alias_lat");
        check("fault_after_wr", 32'(b2.WriteFault), 32'd0);

        // Overwrite: old word visible during RESPOND, new word only after the closing edge.
        access(1'b0, 1'b1, 16'h0200, 32'hA5A5A5A5, 3, 32'h0, "wr_0200_lat");
        pa2 = 8'h80;
        push(1'b0, 1'b0, 32'h0);
        drive(1'b0, 1'b1, 1'b1, 16'h0200, 32'h0F0F0F0F);
        wait_ready(1'b0, 3, "ovw_lat");
        #1 check("no_early_write", pd2, 32'hA5A5A5A5);
        drive(1'b0, 1'b0, 1'b1, 16'h0200, 32'h0F0F0F0F);
        @(posedge CLK); #1;
        check("write_visible", pd2, 32'h0F0F0F0F);

        // Request dropped in WAIT: no Ready, no write.
        drive(1'b0, 1'b1, 1'b1, 16'h0200, 32'h5A5A5A5A);
        @(posedge CLK); #1;
        drive(1'b0, 1'b0, 1'b1, 16'h0200, 32'h5A5A5A5A);
        repeat (4) @(posedge CLK);
        #1;
        probe(1'b0, 8'h80, 32'h0F0F0F0F, "abort_no_write");
        access(1'b0, 1'b0, 16'h0200, 32'h0, 3, 32'h0F0F0F0F, "rd_after_abort");

        // Reset in WAIT: access dropped, storage untouched.
        access(1'b0, 1'b1, 16'h0300, 32'h11111111, 3, 32'h0, "wr_0300_lat");
        drive(1'b0, 1'b1, 1'b1, 16'h0300, 32'h22222222);
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b1, 16'h0300, 32'h22222222);
        @(posedge CLK); #1;
        check("rstwait_ready", 32'(b2.Ready), 32'd0);
        check("rstwait_memdata", b2.MemData, 32'd0);
        rst_n = 1'b1;
        probe(1'b0, 8'hC0, 32'h11111111, "rstwait_no_write");
        probe(1'b0, 8'h40, 32'hDEADBEEF, "rst_keeps_40");
        probe(1'b0, 8'h80, 32'h0F0F0F0F, "rst_keeps_80");
        access(1'b0, 1'b0, 16'h0300, 32'h0, 3, 32'h11111111, "rd_after_rst");

        // Zero wait states: back-to-back reads with MemRequest held.
        access(1'b1, 1'b1, 16'h0000, 32'h0000CAFE, 1, 32'h0, "w0_wr0_lat");
        access(1'b1, 1'b1, 16'h0004, 32'h0000BEEF, 1, 32'h0, "w0_wr1_lat");
        push(1'b1, 1'b1, 32'h0000CAFE);
        push(1'b1, 1'b1, 32'h0000BEEF);
        drive(1'b1, 1'b1, 1'b0, 16'h0000, 32'h0);
        wait_ready(1'b1, 1, "b2b_first_lat");
        drive(1'b1, 1'b1, 1'b0, 16'h0004, 32'h0);
        wait_ready(1'b1, 2, "b2b_spacing");
        drive(1'b1, 1'b0, 1'b0, 16'h0004, 32'h0);
        @(posedge CLK); #1;

`ifdef MEM_WRITE_PROTECT_EN
        access(1'b0, 1'b1, 16'h0010, 32'h12345678, 3, 32'h0, "prot_wr_lat");
        n_checks++;
        if (pd2 === 32'h12345678 || pa2 != 8'h04) begin
            pa2 = 8'h04;
            #1;
            if (pd2 === 32'h12345678) begin
                n_fail++;
                $display("FAIL prot_no_write: got %h must differ from 12345678", pd2);
            end
        end
        check("prot_fault_set", 32'(b2.WriteFault), 32'd1);
        access(1'b0, 1'b0, 16'h0100, 32'h0, 3, 32'hDEADBEEF, "prot_rd_lat");
        check("prot_fault_sticky", 32'(b2.WriteFault), 32'd1);
        pulse_reset();
        check("prot_fault_cleared", 32'(b2.WriteFault), 32'd0);
`else
        access(1'b0, 1'b1, 16'h0010, 32'h12345678, 3, 32'h0, "noprot_wr_lat");
        probe(1'b0, 8'h04, 32'h12345678, "noprot_written");
        check("noprot_fault", 32'(b2.WriteFault), 32'd0);
        pulse_reset();
        probe(1'b0, 8'h04, 32'h12345678, "noprot_kept");
`endif

        repeat (3) @(posedge CLK);
        #1;
        check("sb_empty_w2", 32'(sb2.size()), 32'd0);
        check("sb_empty_w0", 32'(sb0.size()), 32'd0);
        mon_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
